// File: rtl/gh_pkg.sv
// Shared G-bus definitions used by busgh and its feeder.
// GH_GDELAY sets the minimum legal request spacing.
package gh_pkg;

  typedef enum logic {
    GH_IDLE = 1'b0,
    GH_GAP  = 1'b1
  } gh_state_e;

  localparam int GH_GDELAY      = 4;
  localparam int GH_MIN_SPACING = GH_GDELAY + 2;

endpackage

// File: rtl/gh_byte_fifo.sv
// Byte FIFO with registered level/full and synchronous flush.
// The level counter separates full from empty; pointers wrap freely.
module gh_byte_fifo
  import gh_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_accept,
  output logic [LW-1:0] o_level,
  output logic [LW-1:0] o_level_nxt,
  output logic          o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] L_FULL = LW'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_full;

  logic          w_pop;
  logic          w_push;
  logic [LW-1:0] w_level_nxt;

  assign w_pop    = i_pop && (r_level != '0) && !i_flush;
  // A full FIFO still takes a byte when a pop frees a slot on the same edge.
  assign o_accept = i_push && (!r_full || w_pop);
  assign w_push   = o_accept && !i_flush;

  always_comb begin
    w_level_nxt = r_level;
    if (i_flush) begin
      w_level_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_level_nxt = r_level + 1'b1;
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == L_FULL);
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_data      = r_mem[r_rptr];
  assign o_level     = r_level;
  assign o_level_nxt = w_level_nxt;
  assign o_full      = r_full;

endmodule

// File: rtl/gh_feeder.sv
// Paced byte feeder for busgh: FIFO plus IDLE/GAP request FSM.
// Optional counters issued_cnt/dropped_cnt under GH_FEEDER_STATS_EN.
module gh_feeder
  import gh_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int SPACING = 6,
  parameter int LW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic [LW-1:0] level,
  output logic          overflow,
  output logic          busy,
`ifdef GH_FEEDER_STATS_EN
  output logic [15:0]   issued_cnt,
  output logic [7:0]    dropped_cnt,
`endif
  output logic          dsreq,
  output logic [7:0]    dsdata
);

  localparam logic [7:0] GAP_LOAD = 8'(SPACING - 1);

  gh_state_e     r_state;
  gh_state_e     w_state_nxt;
  logic [7:0]    r_gap;
  logic [7:0]    w_gap_nxt;
  logic          r_req;
  logic          w_req_nxt;
  logic [7:0]    r_data;
  logic          r_ovf;
  logic          r_busy;

  logic          w_pop;
  logic          w_accept;
  logic          w_drop;
  logic [7:0]    w_fifo_data;
  logic [LW-1:0] w_level;
  logic [LW-1:0] w_level_nxt;
  logic          w_full;

  assign w_pop  = (r_state == GH_IDLE) && (w_level != '0) && !flush;
  assign w_drop = wr_en && !w_accept && !flush;

  gh_byte_fifo #(
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_push      (wr_en),
    .i_pop       (w_pop),
    .i_data      (wr_data),
    .o_data      (w_fifo_data),
    .o_accept    (w_accept),
    .o_level     (w_level),
    .o_level_nxt (w_level_nxt),
    .o_full      (w_full)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_req_nxt   = 1'b0;
    unique case (r_state)
      GH_IDLE: begin
        if (w_pop) begin
          w_state_nxt = GH_GAP;
          w_gap_nxt   = GAP_LOAD;
          w_req_nxt   = 1'b1;
        end
      end
      GH_GAP: begin
        w_gap_nxt = r_gap - 8'd1;
        if (r_gap <= 8'd1) begin
          w_state_nxt = GH_IDLE;
          w_gap_nxt   = 8'd0;
        end
      end
    endcase
    if (flush) begin
      w_state_nxt = GH_IDLE;
      w_gap_nxt   = 8'd0;
      w_req_nxt   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= GH_IDLE;
      r_gap   <= 8'd0;
      r_req   <= 1'b0;
      r_data  <= 8'h00;
      r_ovf   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_req   <= w_req_nxt;
      r_busy  <= (w_level_nxt != '0) ||
                 (w_state_nxt == GH_GAP);
      if (w_pop) r_data <= w_fifo_data;
      if (flush) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

`ifdef GH_FEEDER_STATS_EN
  logic [15:0] r_issued;
  logic [7:0]  r_dropped;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issued  <= 16'd0;
      r_dropped <= 8'd0;
    end else if (flush) begin
      r_issued  <= 16'd0;
      r_dropped <= 8'd0;
    end else begin
      if (w_pop) r_issued <= r_issued + 16'd1;
      if (w_drop && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end
    end
  end

  assign issued_cnt  = r_issued;
  assign dropped_cnt = r_dropped;
`endif

  assign full     = w_full;
  assign level    = w_level;
  assign overflow = r_ovf;
  assign busy     = r_busy;
  assign dsreq    = r_req;
  assign dsdata   = r_data;

endmodule
